muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with built-in HI/LO registers, serving the CPU datapath's MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO instructions. It replaces separate multiplier and divider blocks and the HI/LO source muxes with a single sequential engine. The engine has a busy/done handshake for the control-unit FSM, a divide-by-zero flag and a generic operand width. It sits beside the ALU and is fed from the A/B operand registers; `hi_out`/`lo_out` drive the register-file write-back mux.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_sign_fix.sv | 23 ++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit and the control unit that
// decodes MULT/MULTU/DIV/DIVU into op_t.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    // The encoding puts divide in bit 1 and unsigned in bit 0
    function automatic logic isDivideOp(input op_t opSel);
        return opSel[1];
    endfunction

    function automatic logic isSignedOp(input op_t opSel);
        return ~opSel[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation of the raw magnitude results,
// applied in the FIX state before HI/LO are written.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] product,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   remainder,
    input  logic               productNeg,
    input  logic               quotientNeg,
    input  logic               remainderNeg,
    output logic [2*WIDTH-1:0] productFixed,
    output logic [WIDTH-1:0]   quotientFixed,
    output logic [WIDTH-1:0]   remainderFixed
);

    always_comb begin
        productFixed   = productNeg   ? -product   : product;
        quotientFixed  = quotientNeg  ? -quotient  : quotient;
        remainderFixed = remainderNeg ? -remainder : remainder;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers,
// one result bit per cycle, busy/done handshake for the control FSM.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    md_state_t          state;
    op_t                opReg;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   bMag;
    logic               resultNeg;
    logic               remNeg;
    logic               zeroFlag;

    op_t                opIn;
    logic               signedIn;
    logic [WIDTH-1:0]   aMagIn;
    logic [WIDTH-1:0]   bMagIn;
    logic               divZeroIn;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH+1:0]   divShift;
    logic [WIDTH+1:0]   divDiff;
    logic               divFits;

    logic [2*WIDTH-1:0] productFixed;
    logic [WIDTH-1:0]   quotientFixed;
    logic [WIDTH-1:0]   remainderFixed;

    // Operand capture: magnitudes for signed ops, raw values otherwise
    always_comb begin
        opIn      = op_t'(op);
        signedIn  = isSignedOp(opIn);
        aMagIn    = (signedIn && a[WIDTH-1]) ? -a : a;
        bMagIn    = (signedIn && b[WIDTH-1]) ? -b : b;
        divZeroIn = isDivideOp(opIn) && (b == '0);
    end

    // One iteration step; the divide trial subtraction is two bits wider than
    // the shifted remainder so its top bit is a clean borrow.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bMag};
        divShift = {rem, acc[WIDTH-1]};
        divDiff  = divShift - {2'b00, bMag};
        divFits  = ~divDiff[WIDTH+1];
    end

    muldiv_sign_fix #(
        .WIDTH(WIDTH)
    ) signFix (
        .product       (acc),
        .quotient      (acc[WIDTH-1:0]),
        .remainder     (rem[WIDTH-1:0]),
        .productNeg    (resultNeg),
        .quotientNeg   (resultNeg),
        .remainderNeg  (remNeg),
        .productFixed  (productFixed),
        .quotientFixed (quotientFixed),
        .remainderFixed(remainderFixed)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= MD_IDLE;
            opReg     <= OP_MULT;
            count     <= '0;
            acc       <= '0;
            rem       <= '0;
            bMag      <= '0;
            resultNeg <= 1'b0;
            remNeg    <= 1'b0;
            zeroFlag  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (wr_hi) hi_out <= wr_data;
                    if (wr_lo) lo_out <= wr_data;
                    if (start) begin
                        opReg     <= opIn;
                        count     <= '0;
                        acc       <= {{WIDTH{1'b0}}, aMagIn};
                        rem       <= '0;
                        bMag      <= bMagIn;
                        resultNeg <= signedIn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        remNeg    <= signedIn && a[WIDTH-1];
                        zeroFlag  <= divZeroIn;
                        busy      <= 1'b1;
                        state     <= divZeroIn ? MD_FIX : MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (isDivideOp(opReg)) begin
                        rem            <= divFits ? divDiff[WIDTH:0] : divShift[WIDTH:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], divFits};
                    end else begin
                        acc <= acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == LAST_COUNT) state <= MD_FIX;
                end
                MD_FIX: begin
                    if (!zeroFlag) begin
                        if (isDivideOp(opReg)) begin
                            lo_out <= quotientFixed;
                            hi_out <= remainderFixed;
                        end else begin
                            lo_out <= productFixed[WIDTH-1:0];
                            hi_out <= productFixed[2*WIDTH-1:WIDTH];
                        end
                    end
                    done     <= 1'b1;
                    div_zero <= zeroFlag;
                    busy     <= 1'b0;
                    state    <= MD_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table-driven vectors, random vectors
// against an arithmetic model, and hand sequences for back-to-back, /0 and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = WIDTH + 2;
    localparam int NUM_VEC = 10;

    logic             clock;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wrHi;
    logic             wrLo;
    logic [WIDTH-1:0] wrData;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          doneAt;
        string       name;
    } expect_t;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        string       name;
    } vector_t;

    expect_t     scoreQ[$];
    expect_t     monExp;
    vector_t     vecTable[NUM_VEC];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycCount   = 0;
    int          doneSeen   = 0;
    logic [31:0] modelHi    = '0;
    logic [31:0] modelLo    = '0;

    muldiv_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wrHi),
        .wr_lo   (wrLo),
        .wr_data (wrData),
        .busy    (busy),
        .done    (done),
        .div_zero(divZero),
        .hi_out  (hiOut),
        .lo_out  (loOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle k after the start edge reads cycCount == startCount + k
    always @(posedge clock) cycCount++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always @(negedge clock) begin
        if (done === 1'b1) begin
            doneSeen++;
            if (scoreQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected done: got done=1 with no operation pending, want 0");
            end else begin
                monExp = scoreQ.pop_front();
                checkOutput({monExp.name, " hi"},    hiOut,    monExp.hi);
                checkOutput({monExp.name, " lo"},    loOut,    monExp.lo);
                checkOutput({monExp.name, " dz"},    divZero,  monExp.dz);
                checkOutput({monExp.name, " cycle"}, cycCount, monExp.doneAt);
                checkOutput({monExp.name, " busy"},  busy,     1'b0);
            end
        end
    end

    // Reference arithmetic, independent of the iterative algorithm
    task automatic modelResult(input op_t o, input logic [31:0] av, input logic [31:0] bv,
                               output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        dz = 1'b0;
        hi = modelHi;
        lo = modelLo;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            OP_MULT: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'b0, av} * {32'b0, bv};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (bv == 0) dz = 1'b1;
                else begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end
            end
            default: begin
                if (bv == 0) dz = 1'b1;
                else begin
                    lo = av / bv;
                    hi = av % bv;
                end
            end
        endcase
    endtask

    // Called at a negedge while the DUT is idle (or in its done cycle)
    task automatic applyStimulus(input op_t o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input logic expDz, input string name);
        expect_t e;
        start    = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        e.hi     = expHi;
        e.lo     = expLo;
        e.dz     = expDz;
        e.doneAt = cycCount + (expDz ? 2 : MUL_LAT);
        e.name   = name;
        scoreQ.push_back(e);
        modelHi  = expHi;
        modelLo  = expLo;
        @(negedge clock);
        start = 1'b0;
        wrHi  = 1'b0;
        wrLo  = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy !== 1'b0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idle timeout: got busy=%b, want 0", busy);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rHi;
        logic [31:0] rLo;
        logic        rDz;
        logic [31:0] ra;
        logic [31:0] rb;
        op_t         ro;
        int          n;
        int          doneBefore;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        wrHi   = 1'b0;
        wrLo   = 1'b0;
        wrData = '0;

        vecTable[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7"};
        vecTable[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max*max"};
        vecTable[2] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
        vecTable[3] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
        vecTable[4] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, "div -100/7"};
        vecTable[5] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, "divu max/16"};
        vecTable[6] = '{OP_DIVU,  32'd5,        32'd9,        32'h00000005, 32'h00000000, "divu 5/9"};
        vecTable[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min"};
        vecTable[8] = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, "multu carry"};
        vecTable[9] = '{OP_MULT,  32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h00000000, "mult -1*0"};

        repeat (3) @(negedge clock);
        checkOutput("reset busy",  busy,    1'b0);
        checkOutput("reset done",  done,    1'b0);
        checkOutput("reset dz",    divZero, 1'b0);
        checkOutput("reset hi",    hiOut,   32'h0);
        checkOutput("reset lo",    loOut,   32'h0);
        reset = 1'b0;

        for (int i = 0; i < NUM_VEC; i++) begin
            waitIdle();
            applyStimulus(vecTable[i].op, vecTable[i].a, vecTable[i].b,
                          vecTable[i].expHi, vecTable[i].expLo, 1'b0, vecTable[i].name);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = op_t'($urandom_range(0, 3));
            modelResult(ro, ra, rb, rHi, rLo, rDz);
            waitIdle();
            applyStimulus(ro, ra, rb, rHi, rLo, rDz, $sformatf("random %0d", i));
        end

        // DIVU issued in the done cycle of a DIV
        waitIdle();
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div -7/2");
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("b2b done seen", done, 1'b1);
        applyStimulus(OP_DIVU, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0, "divu b2b 7/2");

        // MTHI together with start: write visible now, result overwrites later
        waitIdle();
        wrHi   = 1'b1;
        wrData = 32'hDEADBEEF;
        applyStimulus(OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, "multu with wr_hi");
        checkOutput("wr_hi with start", hiOut, 32'hDEADBEEF);

        // Divide by zero leaves preloaded HI/LO alone
        waitIdle();
        wrHi   = 1'b1;
        wrData = 32'h11;
        @(negedge clock);
        wrHi = 1'b0;
        checkOutput("mthi", hiOut, 32'h11);
        wrLo   = 1'b1;
        wrData = 32'h22;
        @(negedge clock);
        wrLo = 1'b0;
        checkOutput("mtlo", loOut, 32'h22);
        applyStimulus(OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, "div by zero");

        // Busy protection, then reset abandons the multiply
        waitIdle();
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clock);
        start = 1'b0;
        checkOutput("busy cycle 1", busy, 1'b1);
        repeat (4) @(negedge clock);
        start  = 1'b1;
        a      = 32'd9;
        b      = 32'd9;
        wrLo   = 1'b1;
        wrData = 32'hAAAA5555;
        @(negedge clock);
        start = 1'b0;
        wrLo  = 1'b0;
        checkOutput("wr_lo ignored busy", loOut, modelLo);
        checkOutput("still busy", busy, 1'b1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        doneBefore = doneSeen;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort busy", busy,  1'b0);
        checkOutput("abort hi",   hiOut, 32'h0);
        checkOutput("abort lo",   loOut, 32'h0);
        checkOutput("abort done", done,  1'b0);
        repeat (50) @(negedge clock);
        checkOutput("no done after abort", doneSeen, doneBefore);
        modelHi = '0;
        modelLo = '0;

        waitIdle();
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult after reset");

        n = 0;
        while (scoreQ.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("pending results", scoreQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
